// File: rtl/xb_gpio_ctrl.sv
// Expansion-board GPIO controller: switch synchronize/debounce with change pulses,
// and per-LED off/on/blink/inverted-blink drive programmed over a valid/ready port.
module xb_gpio_ctrl #(
    parameter logic [15:0] DB_CYCLES  = 16'd50000,
    parameter logic [23:0] BLINK_HALF = 24'd4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  sw_raw,
    output logic [8:0]  sw_state,
    output logic [8:0]  sw_changed,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_addr,
    input  logic [1:0]  cfg_mode,
    output logic        cfg_err,
    input  logic        lamp_test,
    output logic [10:0] led_out
);

    localparam logic [1:0]  MODE_OFF   = 2'b00;
    localparam logic [1:0]  MODE_ON    = 2'b01;
    localparam logic [1:0]  MODE_BLINK = 2'b10;
    localparam logic [1:0]  MODE_INV   = 2'b11;
    localparam logic [3:0]  ADDR_LAST  = 4'd10;
    localparam logic [3:0]  ADDR_BCAST = 4'd15;
    localparam logic [15:0] DB_LAST    = DB_CYCLES - 16'd1;
    localparam logic [23:0] BLINK_LAST = BLINK_HALF - 24'd1;

    logic [8:0]  sync1;
    logic [8:0]  sync2;
    logic [15:0] cnt [9];
    logic [1:0]  mode [11];
    logic [23:0] presc;
    logic        phase;
    logic        cfg_acc;
    logic [10:0] led_next;

    // Handshake: a config word transfers on any rising edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is low only while reset is held.
    assign cfg_acc = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // A bit flips only after DB_CYCLES consecutive differing samples; any agreeing
    // sample discards the partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_state   <= '0;
            sw_changed <= '0;
            for (int i = 0; i < 9; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                sw_changed[i] <= 1'b0;
                if (sync2[i] == sw_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    sw_state[i]   <= ~sw_state[i];
                    sw_changed[i] <= 1'b1;
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < 11; i++) mode[i] <= MODE_OFF;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_acc && (cfg_addr > ADDR_LAST) && (cfg_addr != ADDR_BCAST);
            if (cfg_acc) begin
                for (int i = 0; i < 11; i++) begin
                    if (cfg_addr == ADDR_BCAST || cfg_addr == 4'(i)) mode[i] <= cfg_mode;
                end
            end
        end
    end

    // Free-running blink generator; config writes never restart it.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            phase <= 1'b0;
        end else if (presc == BLINK_LAST) begin
            presc <= '0;
            phase <= ~phase;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < 11; i++) begin
            if (lamp_test) begin
                led_next[i] = 1'b1;
            end else begin
                case (mode[i])
                    MODE_ON:    led_next[i] = 1'b1;
                    MODE_BLINK: led_next[i] = phase;
                    MODE_INV:   led_next[i] = ~phase;
                    default:    led_next[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) led_out <= '0;
        else       led_out <= led_next;
    end

endmodule

// File: tb/tb_xb_gpio_ctrl.sv
// Bench for xb_gpio_ctrl: directed scenarios plus random traffic, checked every
// cycle against a window/arithmetic reference model through an expected queue.
module tb_xb_gpio_ctrl;
  localparam int DB = 4;
  localparam int BH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  sw_raw;
  logic [8:0]  sw_state;
  logic [8:0]  sw_changed;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_mode;
  logic        cfg_err;
  logic        lamp_test;
  logic [10:0] led_out;

  int checks = 0;
  int errors = 0;

  // {sw_state[30:22], sw_changed[21:13], cfg_ready[12], cfg_err[11], led_out[10:0]}
  logic [30:0] exp_q[$];

  logic [8:0] raw_q[$];
  logic [8:0] s_hist[$];
  logic [8:0] m_state;
  logic [1:0] m_mode[11];
  int         m_edges;
  logic       m_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  xb_gpio_ctrl #(.DB_CYCLES(16'(DB)), .BLINK_HALF(24'(BH))) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .sw_state(sw_state),
    .sw_changed(sw_changed),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode),
    .cfg_err(cfg_err),
    .lamp_test(lamp_test),
    .led_out(led_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Switch bit flips when the last DB synchronized samples all disagree with it;
  // synchronized sample = raw sampled two edges earlier (zero just after reset).
  // Blink phase = (edges since reset / BH) mod 2.
  initial begin : model
    logic [8:0]  s;
    logic [8:0]  chg;
    logic [10:0] led;
    logic        err;
    logic        ph;
    logic        acc;
    logic        all_diff;
    forever begin
      @(posedge clk);
      if (reset) begin
        raw_q.delete();
        s_hist.delete();
        m_state = '0;
        for (int i = 0; i < 11; i++) m_mode[i] = 2'b00;
        m_edges = 0;
        m_ready = 1'b0;
        exp_q.push_back('0);
      end else begin
        acc = cfg_valid && m_ready;
        ph  = ((m_edges / BH) % 2) == 1;
        for (int i = 0; i < 11; i++)
          led[i] = lamp_test || (m_mode[i] == 2'b01) || (m_mode[i] == 2'b10 && ph)
                   || (m_mode[i] == 2'b11 && !ph);
        err = acc && (cfg_addr >= 4'd11) && (cfg_addr <= 4'd14);
        if (acc) begin
          if (cfg_addr == 4'd15) begin
            for (int i = 0; i < 11; i++) m_mode[i] = cfg_mode;
          end else if (cfg_addr <= 4'd10) begin
            m_mode[int'(cfg_addr)] = cfg_mode;
          end
        end
        s = (raw_q.size() == 2) ? raw_q[0] : 9'h000;
        raw_q.push_back(sw_raw);
        if (raw_q.size() > 2) void'(raw_q.pop_front());
        s_hist.push_back(s);
        if (s_hist.size() > DB) void'(s_hist.pop_front());
        chg = '0;
        if (s_hist.size() == DB) begin
          for (int b = 0; b < 9; b++) begin
            all_diff = 1'b1;
            foreach (s_hist[k]) if (s_hist[k][b] == m_state[b]) all_diff = 1'b0;
            chg[b] = all_diff;
          end
        end
        m_state = m_state ^ chg;
        m_edges++;
        m_ready = 1'b1;
        exp_q.push_back({m_state, chg, 1'b1, err, led});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [30:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sw_state",   32'(sw_state),   32'(e[30:22]));
        chk("sw_changed", 32'(sw_changed), 32'(e[21:13]));
        chk("cfg_ready",  32'(cfg_ready),  32'(e[12]));
        chk("cfg_err",    32'(cfg_err),    32'(e[11]));
        chk("led_out",    32'(led_out),    32'(e[10:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [3:0] addr, input logic [1:0] md);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_mode  = md;
    @(negedge clk);
  endtask

  task automatic cfg_idle();
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_mode  = '0;
  endtask

  // Counts edges from the next rising edge until a change pulse appears.
  task automatic wait_change(input string name, input int exp_n, input logic [8:0] exp_mask);
    int n = 0;
    bit got = 1'b0;
    logic [8:0] seen = '0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (sw_changed != 9'h000) begin
        got  = 1'b1;
        seen = sw_changed;
      end
    end
    chk({name, "_edges"}, 32'(n), 32'(exp_n));
    chk({name, "_mask"}, 32'(seen), 32'(exp_mask));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    sw_raw    = 9'h1FF;
    lamp_test = 1'b0;
    cfg_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_change("reset_debounce", DB + 2, 9'h1FF);
    repeat (3) @(negedge clk);

    sw_raw = 9'h000;
    repeat (10) @(negedge clk);
    sw_raw[3] = 1'b1;
    repeat (3) @(negedge clk);
    sw_raw[3] = 1'b0;
    repeat (4) @(negedge clk);
    sw_raw[3] = 1'b1;
    wait_change("glitch_hold", DB + 2, 9'h008);
    repeat (3) @(negedge clk);

    cfg_write(4'd2, 2'b01);
    cfg_write(4'd4, 2'b10);
    cfg_idle();
    repeat (12) @(negedge clk);

    cfg_write(4'd15, 2'b11);
    cfg_write(4'd12, 2'b01);
    cfg_idle();
    repeat (8) @(negedge clk);

    cfg_write(4'd15, 2'b00);
    cfg_idle();
    repeat (2) @(negedge clk);
    lamp_test = 1'b1;
    repeat (2) @(negedge clk);
    lamp_test = 1'b0;
    repeat (4) @(negedge clk);

    sw_raw[0] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_change("midop_reset", DB + 2, 9'h009);
    repeat (4) @(negedge clk);

    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 9; b++)
        if ($urandom_range(0, 15) == 0) sw_raw[b] = ~sw_raw[b];
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_addr  = 4'($urandom_range(0, 15));
      cfg_mode  = 2'($urandom_range(0, 3));
      lamp_test = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    cfg_idle();
    lamp_test = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
